// File: rtl/bump_nav_ctrl.sv
// ============================================================================
// Module   : bump_nav_ctrl
// Brief    : Debounced N-bumper drive sequencer with hit-streak fault latch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bump_nav_ctrl #(
  parameter int NB     = 6,
  parameter int SEC    = 3000000,
  parameter int REV_T  = 3,
  parameter int TURN_T = 2,
  parameter int SPIN_T = 4,
  parameter int DEB    = 16,
  parameter int WIN_T  = 5,
  parameter int MAXHIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic [NB-1:0]                 bmp,
  output logic [2:0]                    drive,
  output logic                          fault,
  output logic [$clog2(MAXHIT+1)-1:0]   streak,
  output logic                          busy
);

  localparam int          c_half    = NB / 2;
  localparam int          c_sw      = $clog2(MAXHIT + 1);
  localparam int          c_dbw     = $clog2(DEB + 1);
  localparam logic [31:0] c_rev_ld  = 32'(REV_T * SEC - 1);
  localparam logic [31:0] c_turn_ld = 32'(TURN_T * SEC - 1);
  localparam logic [31:0] c_spin_ld = 32'(SPIN_T * SEC - 1);
  localparam logic [31:0] c_win     = 32'(WIN_T * SEC);

  typedef logic [c_sw-1:0] streak_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_REV   = 3'd2,
    S_LEFT  = 3'd3,
    S_RIGHT = 3'd4,
    S_SPIN  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_tmr, w_tmr_nxt;
  logic [31:0]       r_fwd_cnt;
  logic [c_dbw-1:0]  r_db_cnt;
  logic [NB-1:0]     r_mask;
  streak_t           r_streak, w_streak_nxt, w_streak_hit;
  logic              w_hit, w_centre, w_right, w_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
    end else if (&bmp) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt != c_dbw'(DEB)) begin
      r_db_cnt <= r_db_cnt + c_dbw'(1);
    end
  end

  assign w_hit    = (r_state == S_FWD) && (r_db_cnt == c_dbw'(DEB));
  assign w_centre = r_mask[c_half-1] | r_mask[c_half];
  assign w_right  = |r_mask[c_half-1:0];
  assign w_left   = |r_mask[NB-1:c_half];

  // A hit outside the window restarts the streak at 1 rather than extending it.
  assign w_streak_hit = (r_fwd_cnt < c_win)
                      ? ((r_streak >= streak_t'(MAXHIT)) ? streak_t'(MAXHIT)
                                                         : r_streak + streak_t'(1))
                      : streak_t'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_streak  <= '0;
      r_mask    <= '0;
      r_fwd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tmr    <= w_tmr_nxt;
      r_streak <= w_streak_nxt;
      if (w_hit && !stop) begin
        r_mask <= ~bmp;
      end
      // Held at zero outside FORWARD so every entry starts a fresh window.
      if (r_state != S_FWD) begin
        r_fwd_cnt <= '0;
      end else if (r_fwd_cnt != c_win) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_nxt    = (r_tmr != 32'd0) ? r_tmr - 32'd1 : 32'd0;
    w_streak_nxt = r_streak;
    if (stop && (r_state != S_FAULT)) begin
      w_state_nxt  = S_IDLE;
      w_tmr_nxt    = 32'd0;
      w_streak_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt  = S_FWD;
            w_streak_nxt = '0;
          end
        end
        S_FWD: begin
          if (w_hit) begin
            w_streak_nxt = w_streak_hit;
            if (w_streak_hit == streak_t'(MAXHIT)) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_state_nxt = S_REV;
              w_tmr_nxt   = c_rev_ld;
            end
          end
        end
        S_REV: begin
          if (r_tmr == 32'd0) begin
            if (w_centre || (r_streak >= streak_t'(2))) begin
              w_state_nxt = S_SPIN;
              w_tmr_nxt   = c_spin_ld;
            end else if (w_right) begin
              w_state_nxt = S_LEFT;
              w_tmr_nxt   = c_turn_ld;
            end else if (w_left) begin
              w_state_nxt = S_RIGHT;
              w_tmr_nxt   = c_turn_ld;
            end else begin
              w_state_nxt = S_FWD;
            end
          end
        end
        S_LEFT, S_RIGHT, S_SPIN: begin
          if (r_tmr == 32'd0) begin
            w_state_nxt = S_FWD;
          end
        end
        S_FAULT: begin
          if (start) begin
            w_state_nxt  = S_FWD;
            w_streak_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    drive = 3'd0;
    case (r_state)
      S_FWD:           drive = 3'd1;
      S_REV:           drive = 3'd4;
      S_LEFT:          drive = 3'd3;
      S_RIGHT, S_SPIN: drive = 3'd2;
      default:         drive = 3'd0;
    endcase
  end

  assign fault  = (r_state == S_FAULT);
  assign busy   = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign streak = r_streak;

endmodule

`default_nettype wire

// File: tb/tb_bump_nav_ctrl.sv
// ============================================================================
// Module   : tb_bump_nav_ctrl
// Brief    : Directed self-checking bench for bump_nav_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bump_nav_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [5:0] bmp;
  logic [2:0] drive;
  logic       fault, busy;
  logic [2:0] streak;

  int n_err = 0;
  int n_chk = 0;

  bump_nav_ctrl #(
    .NB(6), .SEC(10), .REV_T(3), .TURN_T(2), .SPIN_T(4),
    .DEB(4), .WIN_T(5), .MAXHIT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .bmp(bmp),
    .drive(drive), .fault(fault), .streak(streak), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press a pattern until the controller leaves FORWARD, then release.
  task automatic do_hit(input logic [5:0] pat, output int lat);
    bmp = pat;
    lat = 0;
    while (drive === 3'd1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    bmp = 6'h3F;
  endtask

  task automatic span(input logic [2:0] code, output int n);
    n = 0;
    while (drive === code && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_fwd(output int n);
    n = 0;
    while (drive !== 3'd1 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; bmp = 6'h3F;
    tick(3);
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL reset_drive: got %0d want 0", drive); end
    n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %0d want 0", fault); end
    n_chk++; if (streak !== 3'd0) begin n_err++; $display("FAIL reset_streak: got %0d want 0", streak); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0d want 0", busy); end
    rst = 1'b0;
    tick(2);
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d want 0", drive); end
  endtask

  task automatic test_glitch();
    start = 1'b1; tick(1); start = 1'b0;
    n_chk++; if (drive !== 3'd1) begin n_err++; $display("FAIL start_drive: got %0d want 1", drive); end
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %0d want 1", busy); end
    bmp = 6'b111110; tick(3); bmp = 6'h3F;
    tick(10);
    n_chk++; if (drive !== 3'd1) begin n_err++; $display("FAIL glitch_drive: got %0d want 1", drive); end
    n_chk++; if (streak !== 3'd0) begin n_err++; $display("FAIL glitch_streak: got %0d want 0", streak); end
  endtask

  task automatic test_right_bump();
    int lat, n;
    do_hit(6'b111110, lat);
    n_chk++; if (lat !== 5) begin n_err++; $display("FAIL hit_latency: got %0d want 5", lat); end
    n_chk++; if (drive !== 3'd4) begin n_err++; $display("FAIL rb_reverse: got %0d want 4", drive); end
    n_chk++; if (streak !== 3'd1) begin n_err++; $display("FAIL rb_streak: got %0d want 1", streak); end
    span(3'd4, n);
    n_chk++; if (n !== 30) begin n_err++; $display("FAIL rb_rev_len: got %0d want 30", n); end
    n_chk++; if (drive !== 3'd3) begin n_err++; $display("FAIL rb_turn: got %0d want 3", drive); end
    span(3'd3, n);
    n_chk++; if (n !== 20) begin n_err++; $display("FAIL rb_turn_len: got %0d want 20", n); end
    n_chk++; if (drive !== 3'd1) begin n_err++; $display("FAIL rb_fwd: got %0d want 1", drive); end
    n_chk++; if (streak !== 3'd1) begin n_err++; $display("FAIL rb_streak_end: got %0d want 1", streak); end
  endtask

  task automatic test_left_bump();
    int lat, n;
    tick(60);
    do_hit(6'b011111, lat);
    n_chk++; if (drive !== 3'd4) begin n_err++; $display("FAIL lb_reverse: got %0d want 4", drive); end
    n_chk++; if (streak !== 3'd1) begin n_err++; $display("FAIL lb_streak: got %0d want 1", streak); end
    span(3'd4, n);
    n_chk++; if (n !== 30) begin n_err++; $display("FAIL lb_rev_len: got %0d want 30", n); end
    n_chk++; if (drive !== 3'd2) begin n_err++; $display("FAIL lb_turn: got %0d want 2", drive); end
    span(3'd2, n);
    n_chk++; if (n !== 20) begin n_err++; $display("FAIL lb_turn_len: got %0d want 20", n); end
    n_chk++; if (drive !== 3'd1) begin n_err++; $display("FAIL lb_fwd: got %0d want 1", drive); end
  endtask

  task automatic test_centre_and_repeat();
    int lat, n;
    tick(60);
    do_hit(6'b110111, lat);
    n_chk++; if (streak !== 3'd1) begin n_err++; $display("FAIL ctr_streak: got %0d want 1", streak); end
    span(3'd4, n);
    n_chk++; if (n !== 30) begin n_err++; $display("FAIL ctr_rev_len: got %0d want 30", n); end
    n_chk++; if (drive !== 3'd2) begin n_err++; $display("FAIL ctr_spin: got %0d want 2", drive); end
    span(3'd2, n);
    n_chk++; if (n !== 40) begin n_err++; $display("FAIL ctr_spin_len: got %0d want 40", n); end
    n_chk++; if (drive !== 3'd1) begin n_err++; $display("FAIL ctr_fwd: got %0d want 1", drive); end
    tick(5);
    do_hit(6'b111110, lat);
    n_chk++; if (streak !== 3'd2) begin n_err++; $display("FAIL rep_streak: got %0d want 2", streak); end
    span(3'd4, n);
    n_chk++; if (n !== 30) begin n_err++; $display("FAIL rep_rev_len: got %0d want 30", n); end
    n_chk++; if (drive !== 3'd2) begin n_err++; $display("FAIL rep_spin: got %0d want 2", drive); end
    span(3'd2, n);
    n_chk++; if (n !== 40) begin n_err++; $display("FAIL rep_spin_len: got %0d want 40", n); end
  endtask

  task automatic test_fault();
    int lat, n;
    tick(60);
    for (int i = 0; i < 4; i++) begin
      do_hit(6'b111110, lat);
      if (i < 3) begin
        n_chk++; if (streak !== 3'(i + 1)) begin n_err++; $display("FAIL flt_streak%0d: got %0d want %0d", i, streak, i + 1); end
        wait_fwd(n);
        n_chk++; if (n >= 500) begin n_err++; $display("FAIL flt_return%0d: got timeout want forward", i); end
      end
    end
    n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL flt_fault: got %0d want 1", fault); end
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL flt_drive: got %0d want 0", drive); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL flt_busy: got %0d want 0", busy); end
    n_chk++; if (streak !== 3'd4) begin n_err++; $display("FAIL flt_streak_max: got %0d want 4", streak); end
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(2);
    n_chk++; if (fault !== 1'b1) begin n_err++; $display("FAIL flt_hold: got %0d want 1", fault); end
    start = 1'b1; tick(1); start = 1'b0;
    n_chk++; if (drive !== 3'd1) begin n_err++; $display("FAIL flt_restart: got %0d want 1", drive); end
    n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL flt_clear: got %0d want 0", fault); end
    n_chk++; if (streak !== 3'd0) begin n_err++; $display("FAIL flt_streak_clr: got %0d want 0", streak); end
  endtask

  task automatic test_stop_reset();
    int lat, n;
    tick(10);
    do_hit(6'b111110, lat);
    n_chk++; if (drive !== 3'd4) begin n_err++; $display("FAIL stp_reverse: got %0d want 4", drive); end
    tick(9);
    stop = 1'b1; start = 1'b1; tick(1); stop = 1'b0; start = 1'b0;
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL stp_drive: got %0d want 0", drive); end
    n_chk++; if (streak !== 3'd0) begin n_err++; $display("FAIL stp_streak: got %0d want 0", streak); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL stp_busy: got %0d want 0", busy); end
    tick(3);
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL stp_idle: got %0d want 0", drive); end
    start = 1'b1; tick(1); start = 1'b0;
    tick(60);
    do_hit(6'b110111, lat);
    span(3'd4, n);
    n_chk++; if (drive !== 3'd2) begin n_err++; $display("FAIL rst_spin: got %0d want 2", drive); end
    tick(10);
    rst = 1'b1; tick(1);
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL rst_drive: got %0d want 0", drive); end
    n_chk++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_fault: got %0d want 0", fault); end
    n_chk++; if (streak !== 3'd0) begin n_err++; $display("FAIL rst_streak: got %0d want 0", streak); end
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d want 0", busy); end
    rst = 1'b0;
    tick(2);
    n_chk++; if (drive !== 3'd0) begin n_err++; $display("FAIL rst_idle: got %0d want 0", drive); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_right_bump();
    test_left_bump();
    test_centre_and_repeat();
    test_fault();
    test_stop_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
